data_memory_pipe: RTL and testbench
===================================

# data_memory_pipe

Parametrised, handshaked successor of the single-cycle data memory for the pipelined core. It is a byte-addressable store of configurable depth with a valid/ready request port and a configurable read latency. It accepts LB/LH/LW/LBU/LHU and SB/SH/SW using the existing DMCtrl encoding, and returns every request's completion on a response port with a fault flag. It sits between the MEM stage and the writeback mux.

## Interface
- DEPTH_BYTES, 4096: memory size in bytes. Power of two, ≥16.
- READ_LAT, 1: cycles from load accept to resp_valid. Legal range 1–4.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept this cycle.
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others are invalid.
- addr  in  32  byte address. Only the low log2(DEPTH_BYTES) bits index the array.
- DataWr  in  32  store data, little-endian.
- resp_valid  out  1  one-cycle completion pulse.
- DataRd  out  32  load result. 0 for stores and faults.
- fault  out  1  qualifies resp_valid: request rejected.

## Operation
- Accept occurs when req_valid && req_ready at a rising edge. Inputs are sampled only at accept.
- At most one request is outstanding.
- req_ready = !busy || resp_valid, which allows back-to-back requests in the response cycle.
- States:
  - IDLE: ready. On accept, go to WAIT with cnt = latency−1.
  - WAIT: decrement cnt. At 0, go to RESP.
  - RESP: resp_valid = 1. On a new accept, go back to WAIT; otherwise go to IDLE.
- Latency is READ_LAT for loads and faults, and 1 for stores.
- Load data is read from the array at the accept edge and held in a pipeline register. A store accepted later cannot alter a pending load's data.
- Load data assembly:
  - Little-endian.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Store write: SB writes 1 byte, SH writes 2 bytes, SW writes 4 bytes at the accept edge. Unaddressed bytes are untouched.
- Fault conditions:
  - H/HU/SH with addr[0]=1.
  - W/SW with addr[1:0]≠0.
  - Invalid DMCtrl.
  - Out-of-range address (see Configuration).
- On a fault, nothing is written, the response arrives after READ_LAT, and it carries fault=1 with DataRd=0.
- Array contents are zero at time 0 and are not affected by rst_n.

## Timing
- Reset values: req_ready=1, resp_valid=0, fault=0, DataRd=0, state IDLE.
- Asserting rst_n mid-operation discards the in-flight request with no response. A store already accepted remains committed.
- Load accepted at edge N: resp_valid is high in the cycle after edge N+READ_LAT−1 (i.e. READ_LAT=1 gives the response in cycle N+1).
- Store accepted at edge N: resp_valid high in cycle N+1. The written data is visible to a load accepted at edge N+1.
- Store and load responses never overlap, because there is a single outstanding request.
- DataRd and fault are held at 0 whenever resp_valid=0.
- Address arithmetic wraps modulo DEPTH_BYTES. Multi-byte access at the top is impossible once aligned.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined: any addr ≥ DEPTH_BYTES (any bit above the index set) faults, with no write and fault=1.
- DMEM_BOUNDS_CHECK_EN undefined: upper address bits are ignored and addresses alias modulo DEPTH_BYTES. This is the legacy behaviour.

## Test plan
- SW addr=0x10, DataWr=0x8899AABB, then LW 0x10, LB 0x13, LBU 0x13, LH 0x12, LHU 0x12. Expected:
  - LW → 0x8899AABB.
  - LB 0x13 → 0xFFFFFF88.
  - LBU 0x13 → 0x00000088.
  - LH 0x12 → 0xFFFF8899.
  - LHU 0x12 → 0x00008899.
- READ_LAT=3, LW accepted at cycle 5: resp_valid exactly in cycle 8. req_ready=0 in cycles 6–7, 1 in cycle 8. A second LW accepted at cycle 8 responds in cycle 11.
- SH addr=0x21 → fault=1, DataRd=0. A subsequent LW 0x20 returns the unchanged prior value. DMCtrl=011 load also gives fault=1.
- SB 0x40 ← 0x5A over a word 0x11223344 at 0x40: LW 0x40 → 0x1122335A.
- LW issued, rst_n pulsed low before the response: no resp_valid. After release req_ready=1, and a new LW responds normally.
- With DMEM_BOUNDS_CHECK_EN, SW 0x1010 at DEPTH_BYTES=4096 → fault=1 and 0x010 unchanged. Without the macro, the same store writes 0x010 and the read-back matches.

Source files
------------

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressable data memory with a valid/ready request
// port, one outstanding request and a configurable read latency.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN. When it is defined, any
// address with bits set above the array index faults. When it is undefined,
// upper address bits alias modulo DEPTH_BYTES.
module data_memory_pipe #(
  parameter int DEPTH_BYTES = 4096,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] DataWr,
  output logic        resp_valid,
  output logic [31:0] DataRd,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] pend_data;
  logic        pend_fault;

  // Contents are deliberately not reset: they survive rst_n.
  logic [7:0]  mem [DEPTH_BYTES];

  logic          accept;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic          ctrl_bad, misalign, oob, req_fault;
  logic [31:0]   rd_word;
  logic [2:0]    lat;

  // The response cycle also accepts, so requests can run back-to-back.
  assign req_ready = (state == IDLE) || resp_valid;
  assign accept    = req_valid && req_ready;

  // Byte lanes wrap inside the array; aligned accesses never actually wrap.
  assign idx0 = addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |addr[31:AW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];
  assign oob = 1'b0;
`endif

  // Decode the access type: legal encodings and the alignment they need.
  always_comb begin
    ctrl_bad = 1'b0;
    misalign = 1'b0;
    case (DMCtrl)
      3'b000:         misalign = 1'b0;
      3'b001, 3'b101: misalign = addr[0];
      3'b010:         misalign = |addr[1:0];
      3'b100:         misalign = 1'b0;
      default:        ctrl_bad = 1'b1;
    endcase
    // Unsigned variants have no meaning for a store.
    if (DMWr && DMCtrl[2]) ctrl_bad = 1'b1;
  end

  assign req_fault = ctrl_bad || misalign || oob;

  // Little-endian load assembly with sign or zero extension.
  always_comb begin
    rd_word = 32'd0;
    case (DMCtrl)
      3'b000:  rd_word = {{24{mem[idx0][7]}}, mem[idx0]};
      3'b001:  rd_word = {{16{mem[idx1][7]}}, mem[idx1], mem[idx0]};
      3'b010:  rd_word = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
      3'b100:  rd_word = {24'd0, mem[idx0]};
      3'b101:  rd_word = {16'd0, mem[idx1], mem[idx0]};
      default: rd_word = 32'd0;
    endcase
  end

  // Clean stores take one cycle; loads and every fault take READ_LAT.
  assign lat = (DMWr && !req_fault) ? 3'd1 : 3'(READ_LAT);

  // Store commit at the accept edge; a faulting store writes nothing.
  always_ff @(posedge clk) begin
    if (rst_n && accept && DMWr && !req_fault) begin
      case (DMCtrl)
        3'b000: mem[idx0] <= DataWr[7:0];
        3'b001: begin
          mem[idx0] <= DataWr[7:0];
          mem[idx1] <= DataWr[15:8];
        end
        3'b010: begin
          mem[idx0] <= DataWr[7:0];
          mem[idx1] <= DataWr[15:8];
          mem[idx2] <= DataWr[23:16];
          mem[idx3] <= DataWr[31:24];
        end
        default: ;
      endcase
    end
  end

  // Request FSM; load data is captured at accept so later stores cannot
  // disturb it. Outputs are registered and held at zero outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      pend_data  <= 32'd0;
      pend_fault <= 1'b0;
      resp_valid <= 1'b0;
      DataRd     <= 32'd0;
      fault      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      DataRd     <= 32'd0;
      fault      <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            if (lat == 3'd1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              fault      <= req_fault;
              DataRd     <= (DMWr || req_fault) ? 32'd0 : rd_word;
            end else begin
              state      <= WAIT;
              cnt        <= 2'(lat - 3'd2);
              pend_data  <= (DMWr || req_fault) ? 32'd0 : rd_word;
              pend_fault <= req_fault;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            fault      <= pend_fault;
            DataRd     <= pend_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Testbench for data_memory_pipe: directed vector table, hand-written
// timing sequences, and randomized traffic against a byte-array model.
module tb_data_memory_pipe;

  localparam int DEPTH = 4096;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] DataWr = 32'd0;
  logic        resp_valid;
  logic [31:0] DataRd;
  logic        fault;

  int tests = 0;
  int fails = 0;

  bit [7:0] mdl [DEPTH];

  data_memory_pipe #(.DEPTH_BYTES(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .addr(addr), .DataWr(DataWr),
    .resp_valid(resp_valid), .DataRd(DataRd), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    bit          ef;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference behaviour from the access rules: size, signedness, fault, bytes.
  task automatic mdl_req(input bit wr, input logic [2:0] ctrl, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] ed, output bit ef);
    int sz;
    int base;
    longint v;
    bit bad;
    bad = !(ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (wr && ctrl[2]);
    sz  = 1 << ctrl[1:0];
    if (!bad && (a % sz) != 0) bad = 1;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (a >= DEPTH) bad = 1;
`endif
    ed = 32'd0;
    ef = bad;
    if (bad) return;
    base = int'(a % DEPTH);
    if (wr) begin
      for (int i = 0; i < sz; i++) mdl[(base + i) % DEPTH] = 8'((d >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(mdl[(base + i) % DEPTH]) << (8 * i));
      if (!ctrl[2] && sz < 4 && v[8 * sz - 1]) v = v - (longint'(1) << (8 * sz));
      ed = v[31:0];
    end
  endtask

  // One full transaction: drive, accept, wait (bounded) for the response.
  task automatic do_req(input string nm, input bit wr, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input bit ef);
    int n;
    int exp_lat;
    bit seen;
    bit quiet;
    logic [31:0] gd;
    logic gf;
    exp_lat = (wr && !ef) ? 1 : LAT;
    @(negedge clk);
    chk({nm, "_rdy"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; DMWr = wr; DMCtrl = ctrl; addr = a; DataWr = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; seen = 0; quiet = 1; gd = 32'hX; gf = 1'bX;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (resp_valid) begin
        seen = 1; gd = DataRd; gf = fault;
      end else if (DataRd != 0 || fault || req_ready) begin
        quiet = 0;
      end
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_data"}, gd, ed);
    chk({nm, "_fault"}, {31'd0, gf}, {31'd0, ef});
    chk({nm, "_quiet"}, {31'd0, quiet}, 32'd1);
  endtask

  initial begin
    logic [31:0] ed;
    bit ef;
    logic [2:0] csel [8];
    csel[0] = 3'b000; csel[1] = 3'b001; csel[2] = 3'b010; csel[3] = 3'b100;
    csel[4] = 3'b101; csel[5] = 3'b010; csel[6] = 3'b011; csel[7] = 3'b111;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_data", DataRd, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    tbl.push_back('{1, 3'b010, 32'h10,  32'h8899AABB, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'h10,  32'h0,        32'h8899AABB, 0});
    tbl.push_back('{0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF88, 0});
    tbl.push_back('{0, 3'b100, 32'h13,  32'h0,        32'h00000088, 0});
    tbl.push_back('{0, 3'b001, 32'h12,  32'h0,        32'hFFFF8899, 0});
    tbl.push_back('{0, 3'b101, 32'h12,  32'h0,        32'h00008899, 0});
    tbl.push_back('{1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        0});
    tbl.push_back('{1, 3'b001, 32'h21,  32'h1234,     32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 0});
    tbl.push_back('{0, 3'b011, 32'h20,  32'h0,        32'h0,        1});
    tbl.push_back('{1, 3'b010, 32'h40,  32'h11223344, 32'h0,        0});
    tbl.push_back('{1, 3'b000, 32'h40,  32'hFFFFFF5A, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'h40,  32'h0,        32'h1122335A, 0});
    tbl.push_back('{0, 3'b010, 32'h22,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 3'b101, 32'h23,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 3'b010, 32'hFFC, 32'h0,        32'h0,        0});
    tbl.push_back('{1, 3'b010, 32'hFFC, 32'h01020304, 32'h0,        0});
    tbl.push_back('{0, 3'b010, 32'hFFC, 32'h0,        32'h01020304, 0});
`ifdef DMEM_BOUNDS_CHECK_EN
    tbl.push_back('{1, 3'b010, 32'h1010, 32'hDEADBEEF, 32'h0,       1});
    tbl.push_back('{0, 3'b010, 32'h10,   32'h0,        32'h8899AABB, 0});
`else
    tbl.push_back('{1, 3'b010, 32'h1010, 32'hDEADBEEF, 32'h0,       0});
    tbl.push_back('{0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0});
`endif
    foreach (tbl[i]) begin
      mdl_req(tbl[i].wr, tbl[i].ctrl, tbl[i].a, tbl[i].d, ed, ef);
      do_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].ctrl, tbl[i].a, tbl[i].d,
             tbl[i].ed, tbl[i].ef);
    end

    // Back-to-back loads: second accepted in the first one's response cycle
    @(negedge clk);
    req_valid = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) req_valid = 1'b0;
      chk($sformatf("b2b_rv%0d", k), {31'd0, resp_valid}, {31'd0, (k == 3 || k == 6)});
      chk($sformatf("b2b_rdy%0d", k), {31'd0, req_ready}, {31'd0, (k == 3 || k == 6)});
      if (k == 3) begin
        chk("b2b_d1", DataRd, 32'h1122335A);
        req_valid = 1'b1; addr = 32'hFFC;
      end
      if (k == 6) chk("b2b_d2", DataRd, 32'h01020304);
    end

    // Store then a load of the same word accepted on the very next edge
    mdl_req(1, 3'b010, 32'h80, 32'h76543210, ed, ef);
    @(negedge clk);
    req_valid = 1'b1; DMWr = 1'b1; DMCtrl = 3'b010; addr = 32'h80; DataWr = 32'h76543210;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) req_valid = 1'b0;
      chk($sformatf("sl_rv%0d", k), {31'd0, resp_valid}, {31'd0, (k == 1 || k == 4)});
      if (k == 1) begin
        req_valid = 1'b1; DMWr = 1'b0;
      end
      if (k == 4) chk("sl_data", DataRd, 32'h76543210);
    end

    // Reset while a load is in flight: no response afterwards
    @(negedge clk);
    req_valid = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; addr = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rv", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rv%0d", k), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("post_rst_rdy%0d", k), {31'd0, req_ready}, 32'd1);
    end
    do_req("post_rst_lw", 0, 3'b010, 32'h40, 32'h0, 32'h1122335A, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit          wr;
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] d;
      wr = 1'($urandom_range(0, 1));
      c  = csel[$urandom_range(0, 7)];
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h0000_3000;
      d  = $urandom;
      mdl_req(wr, c, a, d, ed, ef);
      do_req($sformatf("rnd%0d", i), wr, c, a, d, ed, ef);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
